// File: rtl/keypad_responder.sv
// 4x4 matrix-keypad emulator: presents a requested key's contact on row while the scanner drives its col.
// Define KEYPAD_BOUNCE_EN to add contact bounce around the solid hold; the default build gives a clean closure.
module keypad_responder #(
    parameter int HOLD_CYCLES   = 2000000,
    parameter int BOUNCE_CYCLES = 50000,
    parameter int BOUNCE_PHASES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic       req,
    input  logic [3:0] key_code,
    output logic       busy,
    output logic       done,
    output logic       pressed
);

    // state     | meaning
    // IDLE      | contact open, waiting for req
    // PRESS_BNC | contact alternating closed/open, starting closed
    // HOLD      | contact solidly closed for HOLD_CYCLES
    // REL_BNC   | contact alternating open/closed, starting open

    localparam int CNT_MAX = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 1 || BOUNCE_CYCLES < 1 || BOUNCE_PHASES < 2 || (BOUNCE_PHASES % 2) != 0) begin : g_bad_params
        $error("keypad_responder: invalid timing parameters");
    end

`ifdef KEYPAD_BOUNCE_EN
    localparam int PW = $clog2(BOUNCE_PHASES + 1);
    localparam logic [CW-1:0] BNC_LOAD = CW'(BOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] LAST_PH  = PW'(BOUNCE_PHASES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_BNC, HOLD, REL_BNC} state_t;

    logic [PW-1:0] ph, ph_nxt, ph_inc;
`else
    typedef enum logic {IDLE, HOLD} state_t;
`endif

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          contact, contact_nxt;
    logic          done_nxt;
    logic          latch;
    logic [3:0]    key_q;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        contact_nxt = contact;
        done_nxt    = 1'b0;
        latch       = 1'b0;
`ifdef KEYPAD_BOUNCE_EN
        ph_nxt      = ph;
        ph_inc      = ph + 1'b1;
`endif
        case (state)
            IDLE: begin
                if (req) begin
                    latch       = 1'b1;
                    contact_nxt = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
                    state_nxt   = PRESS_BNC;
                    cnt_nxt     = BNC_LOAD;
                    ph_nxt      = '0;
`else
                    state_nxt   = HOLD;
                    cnt_nxt     = HOLD_LOAD;
`endif
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            PRESS_BNC: begin
                if (cnt == '0) begin
                    if (ph == LAST_PH) begin
                        state_nxt   = HOLD;
                        cnt_nxt     = HOLD_LOAD;
                        contact_nxt = 1'b1;
                    end else begin
                        ph_nxt      = ph_inc;
                        cnt_nxt     = BNC_LOAD;
                        contact_nxt = ~ph_inc[0];
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
`endif
            HOLD: begin
                if (cnt == '0) begin
                    contact_nxt = 1'b0;
`ifdef KEYPAD_BOUNCE_EN
                    state_nxt   = REL_BNC;
                    cnt_nxt     = BNC_LOAD;
                    ph_nxt      = '0;
`else
                    state_nxt   = IDLE;
                    done_nxt    = 1'b1;
`endif
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            REL_BNC: begin
                if (cnt == '0) begin
                    if (ph == LAST_PH) begin
                        state_nxt   = IDLE;
                        contact_nxt = 1'b0;
                        done_nxt    = 1'b1;
                    end else begin
                        ph_nxt      = ph_inc;
                        cnt_nxt     = BNC_LOAD;
                        contact_nxt = ph_inc[0];
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
`endif
            default: begin
                state_nxt   = IDLE;
                contact_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            contact <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            key_q   <= '0;
`ifdef KEYPAD_BOUNCE_EN
            ph      <= '0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            contact <= contact_nxt;
            busy    <= (state_nxt != IDLE);
            done    <= done_nxt;
            if (latch) key_q <= key_code;
`ifdef KEYPAD_BOUNCE_EN
            ph      <= ph_nxt;
`endif
        end
    end

    assign pressed = contact;

    // Combinational so the scanner sees the contact in the same cycle it drives col.
    always_comb begin
        row = 4'hF;
        if (contact && !col[key_q[1:0]]) row[key_q[3:2]] = 1'b0;
    end

endmodule

// File: tb/tb_keypad_responder.sv
// Randomized bench for keypad_responder against a per-cycle contact-profile reference model.
// Works in both builds; the expected profile follows KEYPAD_BOUNCE_EN.
module tb_keypad_responder;

    localparam int HOLD = 100;
    localparam int BNC  = 5;
    localparam int PH   = 4;
`ifdef KEYPAD_BOUNCE_EN
    localparam int BL   = PH * BNC;
    localparam int LEN  = 2 * PH * BNC + HOLD;
`else
    localparam int BL   = 0;
    localparam int LEN  = HOLD;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col = 4'hF;
    logic [3:0] row;
    logic       req = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       busy, done, pressed;

    int checks = 0;
    int failures = 0;

    keypad_responder #(
        .HOLD_CYCLES  (HOLD),
        .BOUNCE_CYCLES(BNC),
        .BOUNCE_PHASES(PH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .col     (col),
        .row     (row),
        .req     (req),
        .key_code(key_code),
        .busy    (busy),
        .done    (done),
        .pressed (pressed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Contact state k cycles after acceptance, straight from the press/hold/release timeline.
    function automatic logic contact_at(input int k);
        if (k < BL) return ((k / BNC) % 2) == 0;
        if (k < BL + HOLD) return 1'b1;
        return (((k - BL - HOLD) / BNC) % 2) == 1;
    endfunction

    function automatic logic [3:0] row_for(input logic c, input logic [3:0] key, input logic [3:0] cv);
        logic [3:0] r;
        r = 4'hF;
        if (c && cv[key[1:0]] == 1'b0) r[key[3:2]] = 1'b0;
        return r;
    endfunction

    int         m_idx = -1;
    logic       m_done = 1'b0;
    logic [3:0] m_key = 4'h0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_idx  = -1;
            m_done = 1'b0;
            m_key  = 4'h0;
        end else if (m_idx < 0) begin
            m_done = 1'b0;
            if (req) begin
                m_key = key_code;
                m_idx = 0;
            end
        end else begin
            m_idx++;
            m_done = 1'b0;
            if (m_idx == LEN) begin
                m_idx  = -1;
                m_done = 1'b1;
            end
        end
    end

    int done_seen = 0;
    int busy_cycles = 0;

    always @(negedge clk) begin
        if (rst) begin
            logic ec;
            ec = (m_idx >= 0) && contact_at(m_idx);
            chk("busy",    32'(busy),    32'(m_idx >= 0));
            chk("done",    32'(done),    32'(m_done));
            chk("pressed", 32'(pressed), 32'(ec));
            chk("row",     32'(row),     32'(row_for(ec, m_key, col)));
            done_seen   += int'(done);
            busy_cycles += int'(busy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4 * LEN; i++) begin
            if (m_idx < 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_idx(input int target, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4 * LEN; i++) begin
            if (m_idx == target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk({tag, "_timeout"}, 32'(m_idx), 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Async reset with all columns driven.
        #3;
        col = 4'h0;
        rst = 1'b0;
        #1;
        chk("rst_row",     32'(row),     32'hF);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_pressed", 32'(pressed), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Key 6, with a spurious req for key 9 during hold.
        done_seen = 0;
        col = 4'b1011;
        key_code = 4'h6;
        req = 1'b1;
        tick();
        req = 1'b0;
        wait_idx(BL + 50, "k6_mid");
        col = 4'b1011;
        #1;
        chk("k6_row_col2", 32'(row), 32'(4'b1101));
        col = 4'b1110;
        #1;
        chk("k6_row_col0", 32'(row), 32'hF);
        chk("k6_pressed",  32'(pressed), 32'd1);
        tick();
        key_code = 4'h9;
        req = 1'b1;
        tick();
        req = 1'b0;
        col = 4'b1011;
        #1;
        chk("k9_ignored_row", 32'(row), 32'(4'b1101));
        wait_idle("k6");
        for (int i = 0; i < 5; i++) tick();
        chk("k6_done_count", 32'(done_seen), 32'd1);

        // Key F, busy length and bounce timeline.
        done_seen = 0;
        busy_cycles = 0;
        col = 4'b0111;
        key_code = 4'hF;
        req = 1'b1;
        tick();
        req = 1'b0;
        wait_idle("kf");
        for (int i = 0; i < 3; i++) tick();
        chk("kf_busy_len",   32'(busy_cycles), 32'(LEN));
        chk("kf_done_count", 32'(done_seen),   32'd1);

        // Reset at hold cycle 50, then a fresh press.
        done_seen = 0;
        key_code = 4'($urandom_range(0, 15));
        col = 4'h0;
        req = 1'b1;
        tick();
        req = 1'b0;
        wait_idx(BL + 50, "rst_mid");
        rst = 1'b0;
        #1;
        chk("mid_rst_row",     32'(row),     32'hF);
        chk("mid_rst_pressed", 32'(pressed), 32'd0);
        chk("mid_rst_busy",    32'(busy),    32'd0);
        chk("mid_rst_done",    32'(done),    32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_no_done", 32'(done_seen), 32'd0);
        key_code = 4'($urandom_range(0, 15));
        req = 1'b1;
        tick();
        req = 1'b0;
        wait_idle("post_rst");
        tick();
        chk("post_rst_done_count", 32'(done_seen), 32'd1);

        // Back-to-back: req held through the done cycle.
        col = 4'b1110;
        key_code = 4'h0;
        req = 1'b1;
        tick();
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 4 * LEN; i++) begin
                if (done) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            chk("b2b_done_seen", 32'(seen), 32'd1);
        end
        chk("b2b_done_busy", 32'(busy), 32'd0);
        tick();
        req = 1'b0;
        chk("b2b_restart_busy", 32'(busy), 32'd1);
        chk("b2b_row",          32'(row),  32'(4'b1110));
        wait_idle("b2b");

        // Random presses with random column scans and stray requests.
        for (int n = 0; n < 8; n++) begin
            key_code = 4'($urandom_range(0, 15));
            req = 1'b1;
            tick();
            req = 1'b0;
            for (int c = 0; c < LEN + 4; c++) begin
                col = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 19) == 0) begin
                    key_code = 4'($urandom_range(0, 15));
                    req = 1'b1;
                end else begin
                    req = 1'b0;
                end
                tick();
            end
            req = 1'b0;
            wait_idle("rand");
        end
        for (int i = 0; i < 3; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
